// File: rtl/demuxn_buffered_if.sv
// demuxn_buffered_if: stream-in / N-lane-out bundle for the buffered demux.
// slave = demux side, master = source/sink side.
interface demuxn_buffered_if #(
  parameter int OUTPUT_NUM  = 4,
  parameter int OUTPUT_SIZE = 8,
  parameter int CNT_W       = 8
);
  localparam int S =
    (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;

  logic [OUTPUT_SIZE-1:0]            in_data;
  logic [S-1:0]                      in_sel;
  logic                              in_valid;
  logic                              in_ready;
  logic [OUTPUT_NUM*OUTPUT_SIZE-1:0] out_data;
  logic [OUTPUT_NUM-1:0]             out_valid;
  logic [OUTPUT_NUM-1:0]             out_ready;
  logic                              bad_sel;
  logic [CNT_W-1:0]                  drop_count;

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output bad_sel,
    output drop_count
  );

  modport master (
    output in_data,
    output in_sel,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  bad_sel,
    input  drop_count
  );
endinterface

// File: rtl/demuxn_buffered.sv
// demuxn_buffered: 1-to-N registered demux, one holding register per lane.
// Ports: clk, rst (sync, active-low), bus (slave): in_* stream, out_* lanes,
// bad_sel pulse and saturating drop_count for out-of-range selects.
module demuxn_buffered #(
  parameter int OUTPUT_NUM  = 4,
  parameter int OUTPUT_SIZE = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  demuxn_buffered_if.slave bus
);
  localparam int S =
    (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
  localparam logic [S:0] NUM_L = OUTPUT_NUM[S:0];

  logic [OUTPUT_NUM-1:0] v_q;
  logic [OUTPUT_NUM-1:0] v_d;
  logic [OUTPUT_NUM-1:0][OUTPUT_SIZE-1:0] d_q;
  logic                  bad_q;
  logic                  bad_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  logic [OUTPUT_NUM-1:0] hit;
  logic [OUTPUT_NUM-1:0] free;
  logic [OUTPUT_NUM-1:0] wr;
  logic                  in_range;
  logic                  acc;

  // One-hot lane decode; stays all-zero for an
  // out-of-range select.
  always_comb begin
    hit = '0;
    for (int i = 0; i < OUTPUT_NUM; i++) begin
      hit[i] = (bus.in_sel == S'(i));
    end
  end

  // A lane can take a word if empty or being
  // drained on this same edge.
  assign free     = ~v_q | bus.out_ready;
  assign in_range = {1'b0, bus.in_sel} < NUM_L;

  // Out-of-range words are always swallowed so
  // they never stall the stream.
  assign bus.in_ready =
    in_range ? |(hit & free) : 1'b1;

  assign acc = bus.in_valid & bus.in_ready;
  assign wr  = acc ? hit : '0;

  // New word wins over a drain on the same lane.
  assign v_d   = wr | (v_q & ~bus.out_ready);
  assign bad_d = acc & ~in_range;

  always_comb begin
    cnt_d = cnt_q;
    if (bad_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q   <= '0;
      d_q   <= '0;
      bad_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      bad_q <= bad_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < OUTPUT_NUM; i++) begin
        if (wr[i]) begin
          d_q[i] <= bus.in_data;
        end
      end
    end
  end

  assign bus.out_valid  = v_q;
  assign bus.out_data   = d_q;
  assign bus.bad_sel    = bad_q;
  assign bus.drop_count = cnt_q;
endmodule

// File: doc/demuxn_buffered.md
Name: demuxn_buffered

Overview:
- Parameterized 1-to-N registered demultiplexer, the distribution side of the N:1 select mux used in the datapath.
- Takes one valid/ready input stream tagged with a destination select and steers each word into one of N output lanes.
- Each lane has a single-entry holding register with its own valid/ready handshake.
- Out-of-range selects, possible when OUTPUT_NUM is not a power of two, are accepted, dropped and counted.

Parameters:
- OUTPUT_NUM, 4, number of output lanes (>=1).
- OUTPUT_SIZE, 8, data width per lane in bits.
- CNT_W, 8, width of the drop counter.
- S (localparam), max(1, $clog2(OUTPUT_NUM)), select width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- in_data  in  OUTPUT_SIZE  word to route.
- in_sel  in  S  destination lane index.
- in_valid  in  1  in_data/in_sel valid.
- in_ready  out  1  block can accept this cycle.
- out_data  out  OUTPUT_NUM*OUTPUT_SIZE  lane i occupies bits [OUTPUT_SIZE*(i+1)-1 : OUTPUT_SIZE*i].
- out_valid  out  OUTPUT_NUM  lane i holds a word.
- out_ready  in  OUTPUT_NUM  lane i consumer accepts.
- bad_sel  out  1  one-cycle pulse after an out-of-range select is accepted.
- drop_count  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (rst==0 at a clock edge) clears all lane valid bits, out_data, bad_sel and drop_count to 0. Reset overrides every other event in that cycle, including an in-flight accept and buffered words, which are discarded.
- Lane state: per lane i, valid bit v[i] drives out_valid[i]; data register d[i] drives its out_data slice.
- in_ready is combinational:
  - in range (in_sel < OUTPUT_NUM): in_ready = !v[in_sel] || out_ready[in_sel].
  - out of range: in_ready = 1.
  - in_ready never depends on in_valid.
- Upstream holds in_data and in_sel stable while in_valid=1 and in_ready=0.
- Accept = in_valid && in_ready at a clock edge.
- In-range accept: d[in_sel] <= in_data and v[in_sel] <= 1. Latency is exactly 1 cycle: the word is visible on out_data/out_valid the cycle after acceptance.
- Output transfer = out_valid[i] && out_ready[i] at a clock edge. It clears v[i] unless the same edge accepts a new word for lane i; in that case v[i] stays 1 and d[i] takes the new word. Each lane sustains 1 word/cycle.
- A lane with v[i]=0 keeps its last d[i]. Consumers must ignore out_data while out_valid is low.
- Lanes are independent: a stalled lane never blocks input traffic addressed to other lanes.
- Out-of-range accept:
  - word is discarded and no lane changes.
  - bad_sel=1 on the following cycle only; back-to-back bad accepts hold it high.
  - drop_count increments by 1 and saturates at 2^CNT_W-1 with no wrap.
- bad_sel is 0 in every cycle not following an out-of-range accept.
- OUTPUT_NUM=1: S=1, sel value 1 is out of range, sel value 0 maps to lane 0.
- out_valid and out_data are pure register outputs; there is no combinational path from in_* to out_*.

Test Plan:
- Reset and basic route: N=3, W=8. Hold rst=0 for 2 cycles, then release; all out_valid=0, drop_count=0. Drive in_sel=2, in_data=0xA5, in_valid=1 for 1 cycle with out_ready=3'b000 -> next cycle out_valid=3'b100, lane 2 data=0xA5, lanes 0 and 1 data=0x00.
- Backpressure: lane 1 full and out_ready[1]=0, offer sel=1 data=0x11 -> in_ready=0 and lane 1 keeps its old word. Offer sel=0 data=0x22 in the same condition -> in_ready=1 and lane 0 gets 0x22 next cycle.
- Full throughput: out_ready[0]=1, stream 0x01,0x02,0x03 to sel=0 on consecutive cycles -> in_ready stays 1, lane 0 shows 0x01,0x02,0x03 on the three following cycles with out_valid[0]=1, and v[0] drops the cycle after the stream ends.
- Out-of-range: N=3, in_sel=3, data=0xFF -> in_ready=1, no out_valid change, bad_sel=1 for one cycle, drop_count=1. With CNT_W=2, send 5 bad words -> drop_count=3.
- Reset mid-operation: lanes 0 and 2 valid; assert rst=0 on a cycle that also accepts sel=1 -> next cycle out_valid=000, out_data=0, drop_count=0, bad_sel=0.
- Randomized scoreboard: 1000 cycles of random valid, sel and out_ready -> per-lane output order matches input order, with no loss or duplication of in-range words.
